// File: rtl/key_sequence_ctrl.sv
// Keypad code-entry controller: buffers up to DIGITS key codes, handles clear,
// backspace and enter, optionally auto-commits a full buffer, and aborts entry
// on inactivity or an external times_up. Committed codes are published with a
// one-cycle o_new_seq strobe.
module key_sequence_ctrl #(
  parameter int unsigned      DIGITS      = 4,
  parameter int unsigned      KEY_W       = 4,
  parameter logic [KEY_W-1:0] ENTER_KEY   = 4'hF,
  parameter logic [KEY_W-1:0] CLEAR_KEY   = 4'hE,
  parameter logic [KEY_W-1:0] BACK_KEY    = 4'hD,
  parameter bit               AUTO_COMMIT = 1'b0,
  parameter int unsigned      TIMEOUT_CYC = 1000
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_key_pressed,
  input  logic [KEY_W-1:0]             i_key,
  input  logic                         i_times_up,
  output logic [DIGITS*KEY_W-1:0]      o_sequence,
  output logic [$clog2(DIGITS+1)-1:0]  o_seq_len,
  output logic                         o_new_seq,
  output logic                         o_entry_active,
  output logic [$clog2(DIGITS+1)-1:0]  o_digit_count,
  output logic                         o_err,
  output logic                         o_timeout
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned SW = DIGITS * KEY_W;
  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {StIdle, StEntry, StFull} state_e;

  state_e          r_state, w_state_nxt;
  logic [SW-1:0]   r_buf, w_buf_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [SW-1:0]   r_seq, w_seq_nxt;
  logic [CW-1:0]   r_len, w_len_nxt;
  logic            r_new_seq, w_new_seq_nxt;
  logic            r_err, w_err_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic [TW-1:0]   r_idle, w_idle_nxt;

  logic            w_active;
  logic            w_is_digit;
  logic            w_idle_hit;
  logic [CW-1:0]   w_count_inc;
  logic [SW-1:0]   w_buf_wr;
  logic [SW-1:0]   w_buf_bs;

  assign w_active    = (r_state != StIdle);
  assign w_is_digit  = (i_key != ENTER_KEY) && (i_key != CLEAR_KEY) && (i_key != BACK_KEY);
  assign w_idle_hit  = (TIMEOUT_CYC != 0) && (r_idle == TW'(TIMEOUT_CYC));
  assign w_count_inc = r_count + CW'(1);

  // Candidate buffers: digit written at slot[count], or slot[count-1] erased.
  always_comb begin
    w_buf_wr = r_buf;
    w_buf_bs = r_buf;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_count == CW'(i))     w_buf_wr[(DIGITS-i)*KEY_W-1 -: KEY_W] = i_key;
      if (r_count == CW'(i + 1)) w_buf_bs[(DIGITS-i)*KEY_W-1 -: KEY_W] = '1;
    end
  end

  // Next-state logic; aborts outrank keys, so a key on an abort cycle is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_count_nxt   = r_count;
    w_seq_nxt     = r_seq;
    w_len_nxt     = r_len;
    w_new_seq_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    w_timeout_nxt = 1'b0;
    w_idle_nxt    = '0;
    if (w_active && !i_key_pressed && (TIMEOUT_CYC != 0)) w_idle_nxt = r_idle + TW'(1);

    if (w_active && (i_times_up || w_idle_hit)) begin
      w_state_nxt   = StIdle;
      w_buf_nxt     = '1;
      w_count_nxt   = '0;
      w_idle_nxt    = '0;
      w_timeout_nxt = !i_times_up;
    end else if (i_key_pressed) begin
      if (w_is_digit) begin
        if (r_state == StFull) begin
          w_err_nxt = 1'b1;
        end else if (w_count_inc == CW'(DIGITS)) begin
          if (AUTO_COMMIT) begin
            w_seq_nxt     = w_buf_wr;
            w_len_nxt     = w_count_inc;
            w_new_seq_nxt = 1'b1;
            w_buf_nxt     = '1;
            w_count_nxt   = '0;
            w_state_nxt   = StIdle;
          end else begin
            w_buf_nxt   = w_buf_wr;
            w_count_nxt = w_count_inc;
            w_state_nxt = StFull;
          end
        end else begin
          w_buf_nxt   = w_buf_wr;
          w_count_nxt = w_count_inc;
          w_state_nxt = StEntry;
        end
      end else if (r_state != StIdle) begin
        if (i_key == ENTER_KEY) begin
          w_seq_nxt     = r_buf;
          w_len_nxt     = r_count;
          w_new_seq_nxt = 1'b1;
          w_buf_nxt     = '1;
          w_count_nxt   = '0;
          w_state_nxt   = StIdle;
        end else if (i_key == CLEAR_KEY) begin
          w_buf_nxt   = '1;
          w_count_nxt = '0;
          w_state_nxt = StIdle;
        end else begin
          w_buf_nxt   = w_buf_bs;
          w_count_nxt = r_count - CW'(1);
          w_state_nxt = (r_count == CW'(1)) ? StIdle : StEntry;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= StIdle;
      r_buf     <= '1;
      r_count   <= '0;
      r_seq     <= '1;
      r_len     <= '0;
      r_new_seq <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_buf     <= w_buf_nxt;
      r_count   <= w_count_nxt;
      r_seq     <= w_seq_nxt;
      r_len     <= w_len_nxt;
      r_new_seq <= w_new_seq_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_timeout_nxt;
      r_idle    <= w_idle_nxt;
    end
  end

  assign o_sequence     = r_seq;
  assign o_seq_len      = r_len;
  assign o_new_seq      = r_new_seq;
  assign o_entry_active = w_active;
  assign o_digit_count  = r_count;
  assign o_err          = r_err;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_key_sequence_ctrl.sv
// Scoreboard bench: stimulus pushes expected pulse events (with the cycle they
// must appear in); a monitor pops and compares whenever a DUT pulses.
module tb_key_sequence_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        kp_a, kp_b, tu_a;
  logic [3:0]  key_a, key_b;
  logic [15:0] seq_a, seq_b;
  logic [2:0]  len_a, len_b, cnt_a, cnt_b;
  logic        ns_a, ns_b, act_a, act_b, err_a, err_b, to_a, to_b;

  key_sequence_ctrl #(
    .DIGITS(4), .KEY_W(4), .ENTER_KEY(4'hF), .CLEAR_KEY(4'hE), .BACK_KEY(4'hD),
    .AUTO_COMMIT(1'b0), .TIMEOUT_CYC(16)
  ) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_key_pressed(kp_a), .i_key(key_a), .i_times_up(tu_a),
    .o_sequence(seq_a), .o_seq_len(len_a), .o_new_seq(ns_a), .o_entry_active(act_a),
    .o_digit_count(cnt_a), .o_err(err_a), .o_timeout(to_a)
  );

  key_sequence_ctrl #(
    .DIGITS(4), .KEY_W(4), .ENTER_KEY(4'hF), .CLEAR_KEY(4'hE), .BACK_KEY(4'hD),
    .AUTO_COMMIT(1'b1), .TIMEOUT_CYC(1000)
  ) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_key_pressed(kp_b), .i_key(key_b), .i_times_up(1'b0),
    .o_sequence(seq_b), .o_seq_len(len_b), .o_new_seq(ns_b), .o_entry_active(act_b),
    .o_digit_count(cnt_b), .o_err(err_b), .o_timeout(to_b)
  );

  // Pulse code is {timeout, err, new_seq}.
  localparam logic [2:0] P_NEW = 3'b001;
  localparam logic [2:0] P_ERR = 3'b010;
  localparam logic [2:0] P_TO  = 3'b100;

  typedef struct packed {
    logic [2:0]  pulse;
    logic [15:0] seq;
    logic [2:0]  len;
    logic [2:0]  cnt;
    logic        act;
  } obs_t;

  typedef struct {
    obs_t obs;
    int   cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    obs_t oa, ob;
    exp_t e;
    oa = {to_a, err_a, ns_a, seq_a, len_a, cnt_a, act_a};
    ob = {to_b, err_b, ns_b, seq_b, len_b, cnt_b, act_b};
    if (oa.pulse != 3'b000) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL mon_a unexpected pulse: got %h at cyc %0d, required none", oa, cyc);
      end else begin
        e = q_a.pop_front();
        if (oa !== e.obs || cyc != e.cyc) begin
          errors++;
          $display("FAIL mon_a: got %h at cyc %0d, required %h at cyc %0d", oa, cyc, e.obs, e.cyc);
        end
      end
    end
    if (ob.pulse != 3'b000) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL mon_b unexpected pulse: got %h at cyc %0d, required none", ob, cyc);
      end else begin
        e = q_b.pop_front();
        if (ob !== e.obs || cyc != e.cyc) begin
          errors++;
          $display("FAIL mon_b: got %h at cyc %0d, required %h at cyc %0d", ob, cyc, e.obs, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic push_a(input logic [2:0] p, input logic [15:0] s, input logic [2:0] l,
                        input logic [2:0] c, input logic a, input int dly);
    exp_t e;
    e.obs = {p, s, l, c, a};
    e.cyc = cyc + dly;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [2:0] p, input logic [15:0] s, input logic [2:0] l,
                        input logic [2:0] c, input logic a, input int dly);
    exp_t e;
    e.obs = {p, s, l, c, a};
    e.cyc = cyc + dly;
    q_b.push_back(e);
  endtask

  // Called at a negedge; key is sampled at the next posedge, returns at the negedge after.
  task automatic press_a(input logic [3:0] k);
    kp_a  = 1'b1;
    key_a = k;
    @(negedge clk);
    kp_a  = 1'b0;
  endtask

  task automatic press_b(input logic [3:0] k);
    kp_b  = 1'b1;
    key_b = k;
    @(negedge clk);
    kp_b  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    kp_a  = 1'b0;
    kp_b  = 1'b0;
    tu_a  = 1'b0;
    key_a = 4'h0;
    key_b = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({seq_a, len_a, cnt_a, act_a, ns_a, err_a, to_a}),
        32'({16'hFFFF, 3'd0, 3'd0, 1'b0, 3'b000}));
    chk("reset_b", 32'({seq_b, len_b, cnt_b, act_b, ns_b, err_b, to_b}),
        32'({16'hFFFF, 3'd0, 3'd0, 1'b0, 3'b000}));
    rst_n = 1'b1;
    @(negedge clk);

    // 1,2,3,ENTER -> 123F, length 3
    press_a(4'h1);
    chk("a_first_digit", 32'({act_a, cnt_a}), 32'({1'b1, 3'd1}));
    press_a(4'h2);
    press_a(4'h3);
    push_a(P_NEW, 16'h123F, 3'd3, 3'd0, 1'b0, 1);
    press_a(4'hF);
    chk("a_commit3", 32'({seq_a, len_a, cnt_a, act_a}), 32'({16'h123F, 3'd3, 3'd0, 1'b0}));

    // Full buffer rejects a fifth digit, then ENTER commits 1234
    press_a(4'h1);
    press_a(4'h2);
    press_a(4'h3);
    press_a(4'h4);
    push_a(P_ERR, 16'h123F, 3'd3, 3'd4, 1'b1, 1);
    press_a(4'h5);
    push_a(P_NEW, 16'h1234, 3'd4, 3'd0, 1'b0, 1);
    press_a(4'hF);

    // Auto-commit instance: 9,8,7,6 commits without ENTER; ENTER in idle is silent
    press_b(4'h9);
    press_b(4'h8);
    press_b(4'h7);
    push_b(P_NEW, 16'h9876, 3'd4, 3'd0, 1'b0, 1);
    press_b(4'h6);
    chk("b_auto_idle", 32'({act_b, cnt_b}), 32'({1'b0, 3'd0}));
    press_b(4'hF);
    repeat (3) @(negedge clk);
    chk("b_seq_hold", 32'({seq_b, len_b}), 32'({16'h9876, 3'd4}));

    // Backspace
    press_a(4'hD);
    chk("a_back_idle", 32'({act_a, cnt_a}), 32'({1'b0, 3'd0}));
    press_a(4'h1);
    press_a(4'h2);
    press_a(4'hD);
    chk("a_back_mid", 32'({act_a, cnt_a}), 32'({1'b1, 3'd1}));
    press_a(4'h3);
    push_a(P_NEW, 16'h13FF, 3'd2, 3'd0, 1'b0, 1);
    press_a(4'hF);
    press_a(4'h1);
    press_a(4'hD);
    chk("a_back_to_idle", 32'({act_a, cnt_a}), 32'({1'b0, 3'd0}));

    // Inactivity: key on the 15th idle cycle restarts the count
    press_a(4'h5);
    repeat (14) @(negedge clk);
    push_a(P_TO, 16'h13FF, 3'd2, 3'd0, 1'b0, 18);
    press_a(4'h6);
    repeat (16) @(negedge clk);
    chk("a_before_timeout", 32'({act_a, cnt_a}), 32'({1'b1, 3'd2}));
    @(negedge clk);
    chk("a_after_timeout", 32'({seq_a, len_a, cnt_a, act_a}), 32'({16'h13FF, 3'd2, 3'd0, 1'b0}));

    // times_up drops a concurrent key and aborts entry
    press_a(4'h1);
    tu_a = 1'b1;
    press_a(4'h7);
    tu_a = 1'b0;
    chk("a_times_up", 32'({seq_a, len_a, cnt_a, act_a}), 32'({16'h13FF, 3'd2, 3'd0, 1'b0}));
    // times_up in idle has no effect; CLEAR then discards
    tu_a = 1'b1;
    press_a(4'h7);
    tu_a = 1'b0;
    chk("a_times_up_idle", 32'({act_a, cnt_a}), 32'({1'b1, 3'd1}));
    press_a(4'hE);
    chk("a_clear", 32'({seq_a, len_a, cnt_a, act_a}), 32'({16'h13FF, 3'd2, 3'd0, 1'b0}));

    // Reset mid-entry
    press_a(4'h1);
    press_a(4'h2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("a_reset_mid", 32'({seq_a, len_a, cnt_a, act_a, ns_a, err_a, to_a}),
        32'({16'hFFFF, 3'd0, 3'd0, 1'b0, 3'b000}));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d/%0d outstanding, required 0/0", q_a.size(), q_b.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_sequence_ctrl.md
Name: key_sequence_ctrl

Overview:
Parametrised keypad code-entry controller that succeeds the fixed 4-digit sequence builder. It collects up to DIGITS key codes from the keypad decoder, supports clear, backspace and enter keys, and optionally auto-commits a full buffer. It also aborts entry on inactivity timeout or an external times_up, and publishes the committed code plus its length to the lock comparator with a one-cycle new_seq strobe.

Parameters:
DIGITS, 4, maximum digits per code (≥1)
KEY_W, 4, key code width
ENTER_KEY, 4'hF, commit code
CLEAR_KEY, 4'hE, discard entry
BACK_KEY, 4'hD, delete last digit
AUTO_COMMIT, 0, 1 = commit automatically when the buffer fills
TIMEOUT_CYC, 1000, inactivity abort threshold in clocks (0 = disabled)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
key_pressed  in  1  single-cycle strobe, key valid this cycle
key  in  KEY_W  key code
times_up  in  1  external abort (level, sampled per clock)
sequence  out  DIGITS*KEY_W  last committed code, slot 0 in MSBs
seq_len  out  $clog2(DIGITS+1)  digit count of committed code
new_seq  out  1  one-cycle commit pulse
entry_active  out  1  high in ENTRY or FULL
digit_count  out  $clog2(DIGITS+1)  digits currently buffered
err  out  1  one-cycle pulse: digit rejected (buffer full)
timeout  out  1  one-cycle pulse: entry aborted by inactivity

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; buffer all-ones; sequence all-ones; seq_len, digit_count, new_seq, err, timeout, and the idle counter all 0.
- Digit = any key code other than ENTER_KEY, CLEAR_KEY or BACK_KEY. Digits fill slots MSB-first: slot i = bits [(DIGITS-i)*KEY_W-1 -: KEY_W]. Unfilled slots hold all-ones.
- States: IDLE, ENTRY, FULL. All updates are visible the cycle after the key_pressed edge.
- IDLE:
  - Digit → slot0 written, count=1, go to ENTRY (or commit if DIGITS=1 and AUTO_COMMIT=1).
  - ENTER, CLEAR and BACK → ignored, no pulses.
- ENTRY:
  - Digit → write slot[count], count+1.
  - If count reaches DIGITS: commit when AUTO_COMMIT=1, else go to FULL.
  - BACK → slot[count-1] reset to all-ones, count-1; count reaching 0 → IDLE.
  - CLEAR → buffer all-ones, count 0, IDLE, no commit.
  - ENTER → commit.
- FULL:
  - Digit → err pulse; buffer unchanged.
  - BACK, CLEAR and ENTER behave as in ENTRY.
- Commit: at the same edge, sequence ← buffer (including the digit just accepted on auto-commit) and seq_len ← count. new_seq=1 for exactly the next cycle. Buffer then resets to all-ones, count to 0, state to IDLE.
- Idle counter:
  - Clears on any key_pressed and on entering IDLE.
  - Increments every cycle in ENTRY or FULL.
  - When it reaches TIMEOUT_CYC, abort: buffer cleared, IDLE, timeout pulse next cycle; sequence and seq_len unchanged.
  - TIMEOUT_CYC=0 disables the counter.
- times_up=1 in ENTRY or FULL: abort as for timeout but with no timeout pulse. In IDLE it has no effect.
- Priority per edge: reset_n > times_up > timeout > key_pressed. A key arriving on an abort cycle is dropped.
- Pulses (new_seq, err, timeout) never last more than one cycle; at most one fires per cycle.
- sequence holds its value until the next commit or reset.

Test Plan:
- DIGITS=4, AUTO_COMMIT=0: keys 1,2,3,F → sequence=16'h123F, seq_len=3, new_seq high exactly 1 cycle after F, digit_count=0.
- Keys 1,2,3,4,5,F with AUTO_COMMIT=0 → err pulse on 5, then sequence=16'h1234, seq_len=4.
- AUTO_COMMIT=1: keys 9,8,7,6 → new_seq after 6, sequence=16'h9876, no ENTER needed; a following F in IDLE produces no pulse.
- Backspace: D in IDLE ignored; then 1,2,D,3,F → sequence=16'h13FF, seq_len=2. Sequence 1,D → IDLE, count 0.
- TIMEOUT_CYC=16: key 5, then 16 idle cycles → timeout pulse, entry_active=0, sequence unchanged. A key on cycle 15 restarts the count.
- Key 7 concurrent with times_up=1 → key dropped, IDLE. reset_n=0 mid-entry (after 1,2) → all outputs at reset values next cycle.
